// File: rtl/i2c_seq_pkg.sv
// Shared state encoding, transaction word layout and word builder
// for the I2C configuration sequencer.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_ACC,
    S_WAIT_DONE,
    S_CHECK,
    S_GAP,
    S_FINISH
  } seq_state_t;

  localparam int DEV_LSB = 16;
  localparam int DEV_W   = 7;
  localparam int REG_LSB = 8;
  localparam int REG_W   = 8;
  localparam int DAT_LSB = 0;
  localparam int DAT_W   = 8;
  localparam int ROM_W   = 24;

  function automatic logic [31:0] I2C_WORD(
    input logic [6:0] dev,
    input logic [7:0] rg,
    input logic [7:0] dat
  );
    logic [31:0] w;
    w = '0;
    w[DEV_LSB +: DEV_W] = dev;
    w[REG_LSB +: REG_W] = rg;
    w[DAT_LSB +: DAT_W] = dat;
    return w;
  endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// Board configuration table: index -> {dev,reg,dat}.
// Codec (0x1A) setup followed by sensor (0x21) setup.
module i2c_config_rom
  import i2c_seq_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [ROM_W-1:0] word_o
);

  always_comb begin
    word_o = '0;
    case (int'(idx_i))
      0:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h1E, 8'h00));
      1:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h0C, 8'h10));
      2:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h00, 8'h17));
      3:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h02, 8'h17));
      4:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h04, 8'h79));
      5:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h06, 8'h79));
      6:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h08, 8'h12));
      7:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h0A, 8'h00));
      8:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h0E, 8'h42));
      9:  word_o = ROM_W'(I2C_WORD(7'h1A, 8'h10, 8'h01));
      10: word_o = ROM_W'(I2C_WORD(7'h1A, 8'h12, 8'h01));
      11: word_o = ROM_W'(I2C_WORD(7'h21, 8'h01, 8'h80));
      12: word_o = ROM_W'(I2C_WORD(7'h21, 8'h02, 8'h3C));
      13: word_o = ROM_W'(I2C_WORD(7'h21, 8'h03, 8'h05));
      14: word_o = ROM_W'(I2C_WORD(7'h21, 8'h10, 8'hAA));
      15: word_o = ROM_W'(I2C_WORD(7'h21, 8'h11, 8'h55));
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the config ROM and drives the I2C write controller handshake.
// Build option: define I2C_SEQ_RETRY_EN to re-issue NACKed entries.
module i2c_config_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NUM_ENTRIES    = 16,
  parameter int IDX_W          = 4,
  parameter int GAP_CYCLES     = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             i2c_start,
  output logic [31:0]      i2c_data,
  input  logic             i2c_done,
  input  logic             i2c_ack,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             cfg_error,
  output logic [7:0]       err_count,
  output logic [IDX_W-1:0] cur_index,
  output logic [IDX_W-1:0] fail_index
);

  localparam int CNT_MAX  = (GAP_CYCLES > TIMEOUT_CYCLES) ?
                            GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TO_LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  seq_state_t        state_q, state_d;
  logic [CW-1:0]     tmr_q, tmr_d;
  logic              start_q, start_d;
  logic [31:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              cdone_q, cdone_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic              done_s1_q, done_s2_q;
  logic              ack_s1_q, ack_s2_q;
  logic              fail;
  logic [ROM_W-1:0]  rom_w;

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 2);
  logic [RW-1:0] retry_q, retry_d;
`endif

  i2c_config_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .idx_i  (idx_q),
    .word_o (rom_w)
  );

  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    data_d    = data_q;
    busy_d    = busy_q;
    cdone_d   = cdone_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    idx_d     = idx_q;
    fidx_d    = fidx_q;
    fail      = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (go) begin
          state_d   = S_LOAD;
          busy_d    = 1'b1;
          cdone_d   = 1'b0;
          err_d     = 1'b0;
          err_cnt_d = '0;
          idx_d     = '0;
          fidx_d    = '0;
`ifdef I2C_SEQ_RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        data_d  = {8'h00, rom_w};
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_WAIT_ACC;
      end
      S_WAIT_ACC: begin
        // acceptance wins over a coincident timeout
        if (!done_s2_q) begin
          start_d = 1'b0;
          state_d = S_WAIT_DONE;
        end else if (tmr_q == CW'(TO_LAST)) begin
          start_d = 1'b0;
          fail    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_WAIT_DONE: begin
        if (done_s2_q) begin
          state_d = S_CHECK;
        end else if (tmr_q == CW'(TO_LAST)) begin
          fail    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_CHECK: begin
        if (ack_s2_q) begin
          state_d = S_GAP;
`ifdef I2C_SEQ_RETRY_EN
        end else if (retry_q < RW'(MAX_RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_LOAD;
`endif
        end else begin
          fail    = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_q == CW'(GAP_LAST)) begin
`ifdef I2C_SEQ_RETRY_EN
          retry_d = '0;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            cdone_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fail) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
      if (!err_q) fidx_d = idx_q;
    end
    tmr_d = (state_d != state_q) ? '0 : tmr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      cdone_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      idx_q     <= '0;
      fidx_q    <= '0;
      done_s1_q <= 1'b1;
      done_s2_q <= 1'b1;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      start_q   <= start_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      cdone_q   <= cdone_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      idx_q     <= idx_d;
      fidx_q    <= fidx_d;
      done_s1_q <= i2c_done;
      done_s2_q <= done_s1_q;
      ack_s1_q  <= i2c_ack;
      ack_s2_q  <= ack_s1_q;
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry_q <= '0;
    else       retry_q <= retry_d;
  end
`endif

  assign i2c_start  = start_q;
  assign i2c_data   = data_q;
  assign cfg_busy   = busy_q;
  assign cfg_done   = cdone_q;
  assign cfg_error  = err_q;
  assign err_count  = err_cnt_q;
  assign cur_index  = idx_q;
  assign fail_index = fidx_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer with a behavioural
// write-controller model; works with or without I2C_SEQ_RETRY_EN.
module tb_i2c_config_sequencer;

  logic        clk;
  logic        reset;

  logic        go, start, done, ack;
  logic [31:0] data;
  logic        busy, cdone, cerr;
  logic [7:0]  ecnt;
  logic [3:0]  cidx, fidx;

  logic        go_b, start_b, done_b, ack_b;
  logic [31:0] data_b;
  logic        busy_b, cdone_b, cerr_b;
  logic [7:0]  ecnt_b;
  logic [3:0]  cidx_b, fidx_b;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_rom [3] = '{32'h001A_1E00, 32'h001A_0C10, 32'h001A_0017};

  int          nack_cnt [16];
  bit          stuck;
  logic [31:0] log_q [$];
  int          mk;
  bit          mnk;

  i2c_config_sequencer #(
    .NUM_ENTRIES(3), .IDX_W(4), .GAP_CYCLES(8),
    .TIMEOUT_CYCLES(100), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .i2c_start(start), .i2c_data(data),
    .i2c_done(done), .i2c_ack(ack),
    .cfg_busy(busy), .cfg_done(cdone), .cfg_error(cerr),
    .err_count(ecnt), .cur_index(cidx), .fail_index(fidx)
  );

  i2c_config_sequencer #(
    .NUM_ENTRIES(16), .IDX_W(4), .GAP_CYCLES(0),
    .TIMEOUT_CYCLES(100), .MAX_RETRIES(3)
  ) dut16 (
    .clk(clk), .reset(reset), .go(go_b),
    .i2c_start(start_b), .i2c_data(data_b),
    .i2c_done(done_b), .i2c_ack(ack_b),
    .cfg_busy(busy_b), .cfg_done(cdone_b), .cfg_error(cerr_b),
    .err_count(ecnt_b), .cur_index(cidx_b), .fail_index(fidx_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write controller model for dut: logs each accepted word
  initial begin
    done = 1'b1;
    ack  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (start && !stuck) begin
        mk = int'(cidx);
        log_q.push_back(data);
        mnk = nack_cnt[mk] > 0;
        if (mnk) nack_cnt[mk]--;
        done = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        ack  = !mnk;
        done = 1'b1;
      end
    end
  end

  // controller model for dut16: NACKs everything
  initial begin
    done_b = 1'b1;
    ack_b  = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (start_b) begin
        done_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        done_b = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_fin(input int budget);
    int n;
    n = 0;
    while (cdone !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go = 1'b0;
    go_b = 1'b0;
    stuck = 1'b0;
    foreach (nack_cnt[i]) nack_cnt[i] = 0;
    repeat (3) step();
    checks++;
    if ({start, data, busy, cdone, cerr, ecnt, cidx, fidx} !== 52'h0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0",
               {start, data, busy, cdone, cerr, ecnt, cidx, fidx});
    end
    checks++;
    if ({start_b, busy_b, cdone_b, cerr_b, ecnt_b} !== 12'h0) begin
      failures++;
      $display("FAIL reset_outs16 got=%h exp=0",
               {start_b, busy_b, cdone_b, cerr_b, ecnt_b});
    end
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_clean_run();
    log_q.delete();
    go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if (busy !== 1'b1 || start !== 1'b0) begin
      failures++;
      $display("FAIL accept busy/start got=%b%b exp=10", busy, start);
    end
    step();
    checks++;
    if (start !== 1'b0) begin
      failures++;
      $display("FAIL start_early got=%b exp=0", start);
    end
    step();
    checks++;
    if (start !== 1'b1) begin
      failures++;
      $display("FAIL start_latency got=%b exp=1", start);
    end
    checks++;
    if (data !== exp_rom[0]) begin
      failures++;
      $display("FAIL load_word got=%h exp=%h", data, exp_rom[0]);
    end
    repeat (4) step();
    go = 1'b1;
    step();
    go = 1'b0;
    wait_fin(400);
    checks++;
    if ({cdone, busy, cerr, ecnt} !== {3'b100, 8'd0}) begin
      failures++;
      $display("FAIL clean_status got=%b%b%b/%0d exp=100/0",
               cdone, busy, cerr, ecnt);
    end
    checks++;
    if (log_q.size() !== 3) begin
      failures++;
      $display("FAIL clean_count got=%0d exp=3", log_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] obs;
      obs = (i < log_q.size()) ? log_q[i] : 32'hx;
      checks++;
      if (obs !== exp_rom[i]) begin
        failures++;
        $display("FAIL clean_word%0d got=%h exp=%h", i, obs, exp_rom[i]);
      end
    end
  endtask

  task automatic test_nack();
    int exp_idx [$];
`ifdef I2C_SEQ_RETRY_EN
    exp_idx = '{0, 1, 1, 2};
`else
    exp_idx = '{0, 1, 2};
`endif
    log_q.delete();
    nack_cnt[1] = 1;
    go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if (cdone !== 1'b0) begin
      failures++;
      $display("FAIL finish_go_clr done got=%b exp=0", cdone);
    end
    wait_fin(600);
    checks++;
    if (cdone !== 1'b1) begin
      failures++;
      $display("FAIL nack_finish got=%b exp=1", cdone);
    end
    checks++;
    if (log_q.size() !== exp_idx.size()) begin
      failures++;
      $display("FAIL nack_count got=%0d exp=%0d",
               log_q.size(), exp_idx.size());
    end
    foreach (exp_idx[i]) begin
      logic [31:0] obs;
      obs = (i < log_q.size()) ? log_q[i] : 32'hx;
      checks++;
      if (obs !== exp_rom[exp_idx[i]]) begin
        failures++;
        $display("FAIL nack_word%0d got=%h exp=%h",
                 i, obs, exp_rom[exp_idx[i]]);
      end
    end
`ifdef I2C_SEQ_RETRY_EN
    checks++;
    if ({cerr, ecnt} !== 9'd0) begin
      failures++;
      $display("FAIL retry_err got=%b/%0d exp=0/0", cerr, ecnt);
    end
`else
    checks++;
    if ({cerr, ecnt, fidx} !== {1'b1, 8'd1, 4'd1}) begin
      failures++;
      $display("FAIL nack_err got=%b/%0d/%0d exp=1/1/1", cerr, ecnt, fidx);
    end
`endif
  endtask

  task automatic test_timeout();
    int n;
    log_q.delete();
    stuck = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    checks++;
    if ({cdone, cerr, ecnt} !== 10'd0) begin
      failures++;
      $display("FAIL go_clears got=%b%b/%0d exp=00/0", cdone, cerr, ecnt);
    end
    n = 0;
    while (start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    n = 0;
    while (start === 1'b1 && n < 300) begin
      step();
      n++;
    end
    checks++;
    if (n !== 100) begin
      failures++;
      $display("FAIL timeout_len got=%0d exp=100", n);
    end
    wait_fin(1000);
    checks++;
    if ({cdone, cerr, ecnt, fidx} !== {2'b11, 8'd3, 4'd0}) begin
      failures++;
      $display("FAIL timeout_status got=%b%b/%0d/%0d exp=11/3/0",
               cdone, cerr, ecnt, fidx);
    end
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    log_q.delete();
    go = 1'b1;
    step();
    go = 1'b0;
    n = 0;
    while (!(cidx == 4'd2 && done === 1'b0 && start === 1'b0) && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (cidx !== 4'd2 || done !== 1'b0) begin
      failures++;
      $display("FAIL reach_wait_done idx got=%0d exp=2", cidx);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({start, data, busy, cdone, cerr, ecnt, cidx, fidx} !== 52'h0) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=0",
               {start, data, busy, cdone, cerr, ecnt, cidx, fidx});
    end
    step();
    reset = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    repeat (4) step();
    log_q.delete();
    go = 1'b1;
    step();
    go = 1'b0;
    wait_fin(400);
    checks++;
    if (log_q.size() !== 3 || (log_q.size() > 0 && log_q[0] !== exp_rom[0])) begin
      failures++;
      $display("FAIL restart got=%0d words first=%h exp=3 %h",
               log_q.size(), (log_q.size() > 0) ? log_q[0] : 32'h0,
               exp_rom[0]);
    end
    checks++;
    if ({cdone, cerr} !== 2'b10) begin
      failures++;
      $display("FAIL restart_status got=%b%b exp=10", cdone, cerr);
    end
  endtask

  task automatic test_saturate();
    int n;
    go_b = 1'b1;
    step();
    go_b = 1'b0;
    force dut16.err_cnt_q = 8'd250;
    step();
    release dut16.err_cnt_q;
    n = 0;
    while (cdone_b !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (cdone_b !== 1'b1) begin
      failures++;
      $display("FAIL sat_finish got=%b exp=1", cdone_b);
    end
    checks++;
    if (ecnt_b !== 8'd255) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=255", ecnt_b);
    end
    checks++;
    if ({cerr_b, fidx_b} !== {1'b1, 4'd0}) begin
      failures++;
      $display("FAIL sat_err got=%b/%0d exp=1/0", cerr_b, fidx_b);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_nack();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_config_sequencer.md
# i2c_config_sequencer

Walks a fixed table of I2C register writes and drives the single-transaction I2C write controller through its start/done/ack handshake, one write at a time. Sits between system control (a `go` pulse from the top level or a Wishbone control register) and the I2C write controller. Codec/sensor power-up configuration can therefore run without CPU involvement. Reports completion, NACKs and timeouts.

## Interface
- `NUM_ENTRIES`, 16: number of table entries executed; range 1..2^IDX_W.
- `IDX_W`, 4: table index width.
- `GAP_CYCLES`, 1024: idle clocks inserted after each completed write; 0 means no gap.
- `TIMEOUT_CYCLES`, 65535: maximum clocks in WAIT_ACC or WAIT_DONE before a timeout is declared.
- `MAX_RETRIES`, 3: re-issues per entry after a NACK; used only with the retry feature.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `go`, in, 1: start-sequence pulse; accepted only in IDLE or FINISH.
- `i2c_start`, out, 1: start request to the write controller.
- `i2c_data`, out, 32: transaction word. Bits [22:16] are the device address, [15:8] the register, [7:0] the data; all other bits are 0.
- `i2c_done`, in, 1: controller done; 1 when idle, 0 while a transfer is in flight.
- `i2c_ack`, in, 1: 1 when all three ACK bits of the last transfer were low.
- `cfg_busy`, out, 1: high from `go` acceptance until FINISH.
- `cfg_done`, out, 1: high in FINISH; cleared by the next accepted `go`.
- `cfg_error`, out, 1: sticky; set on any unrecovered NACK or timeout; cleared by an accepted `go`.
- `err_count`, out, 8: number of failed entries; saturates at 255.
- `cur_index`, out, IDX_W: entry currently being processed.
- `fail_index`, out, IDX_W: index of the first failed entry.

## Operation
- States:
  - IDLE
  - LOAD: register the ROM word for `cur_index` into `i2c_data`.
  - ISSUE: drive `i2c_start`=1.
  - WAIT_ACC: hold `i2c_start` until `i2c_done`=0, which means the controller accepted the start.
  - WAIT_DONE: wait for `i2c_done`=1.
  - CHECK: sample `i2c_ack`.
  - GAP: count GAP_CYCLES idle clocks.
  - FINISH
- Transitions:
  - IDLE or FINISH → LOAD on `go`. This also clears `cur_index`, `err_count`, `cfg_error`, `cfg_done` and `fail_index`.
  - LOAD → ISSUE → WAIT_ACC.
  - WAIT_ACC → WAIT_DONE when `i2c_done`=0. `i2c_start` drops in the same cycle the transition is taken.
  - WAIT_DONE → CHECK when `i2c_done`=1.
  - CHECK: on ACK go to GAP. On NACK, record the failure and go to GAP.
  - GAP → LOAD with `cur_index`+1. If the finished entry was NUM_ENTRIES-1, go to FINISH instead.
- Timeout: a counter resets on every state entry. Reaching TIMEOUT_CYCLES in WAIT_ACC or WAIT_DONE counts as a failure: drop `i2c_start` and go to GAP. There is no retry on timeout.
- Recording a failure: `cfg_error`←1, `err_count`+1 (saturating), and `fail_index` is latched only if this is the first failure.
- `go` in any other state is ignored.
- `i2c_data` is stable from LOAD until the next LOAD. It is never changed while `i2c_start` is high or the controller is busy.

## Timing
- All flops are asynchronous-reset. Reset values:
  - state IDLE
  - `i2c_start` 0
  - `i2c_data` 0
  - `cfg_busy` 0
  - `cfg_done` 0
  - `cfg_error` 0
  - `err_count` 0
  - `cur_index` 0
  - `fail_index` 0
- Outputs are registered.
- `go` to `i2c_start`=1: 3 clocks (accept, LOAD, ISSUE).
- `i2c_done` and `i2c_ack` come from the controller's slow clock domain. Both pass through a 2-flop synchronizer, adding 2 clocks of latency. `i2c_ack` is sampled in CHECK, after synchronized `i2c_done` has been high for at least 1 clock.
- `i2c_start` is held until acceptance. This guarantees capture by the controller's slow-clock start synchronizer.
- Reset mid-transfer: the sequencer returns to IDLE immediately. The controller may finish its transfer independently, and that result is ignored.
- NUM_ENTRIES=1: one transfer, then FINISH.
- A simultaneous timeout and `i2c_done` edge resolves as completion; the timeout does not apply.

## Configuration
- `I2C_SEQ_RETRY_EN` defined: a NACK in CHECK re-enters LOAD for the same index, up to MAX_RETRIES times. A per-entry retry counter resets on every index advance. The failure is recorded only after the retries are exhausted.
- Undefined: the first NACK is recorded and the sequence proceeds. MAX_RETRIES is ignored and no retry counter is synthesized.

## Structure
- Shared package `i2c_seq_pkg`:
  - state enum/localparams
  - the `i2c_data` field offsets (device [22:16], register [15:8], data [7:0])
  - a `I2C_WORD(dev,reg,dat)` construction function
- One sub-module, `i2c_config_rom`: a combinational lookup from IDX_W index to 24-bit {dev,reg,dat} that holds the board's configuration table. The sequencer pads the output to 32 bits.

## Test plan
- Clean run, NUM_ENTRIES=3, controller model ACKs all, GAP_CYCLES=8: expect 3 start handshakes with `i2c_data` matching ROM entries 0..2, then `cfg_done`=1, `cfg_error`=0, `err_count`=0.
- Entry 1 NACKs once, retry build: entry 1 is issued twice and `err_count`=0. Same stimulus, non-retry build: `err_count`=1, `fail_index`=1, and entry 2 is still issued.
- Controller never drops `i2c_done`, TIMEOUT_CYCLES=100: `i2c_start` drops after 100 clocks in WAIT_ACC, `cfg_error`=1, and the sequence advances to FINISH.
- `reset` asserted in WAIT_DONE of entry 2: all outputs return to reset values immediately. A new `go` restarts at entry 0.
- `go` pulsed while `cfg_busy`=1: ignored. `go` in FINISH: `cfg_done`, `cfg_error` and `err_count` clear and the sequence reruns.
- `err_count` saturation: NUM_ENTRIES=16, all NACK, run 17 sequences back-to-back without clearing (force path). `err_count` must stick at 255.
